// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared widths, defaults and FSM encoding for the memory bus initiator
package mem_bus_pkg;

  localparam int AW_DEF      = 16;
  localparam int DW_DEF      = 16;
  localparam int TIMEOUT_DEF = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    REQ_LO = 2'd2,
    RSP    = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_initiator_if.sv
// rtl/mem_initiator_if.sv - REQ/ACK four-phase memory bus between initiator and responder
interface mem_initiator_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic [AW-1:0] ADDR;
  logic [DW-1:0] DIN;
  logic [DW-1:0] DOUT;
  logic          WEN;
  logic          REQ;
  logic          ACK;

  modport master (output ADDR, output DIN, output WEN, output REQ, input DOUT, input ACK);
  modport slave  (input ADDR, input DIN, input WEN, input REQ, output DOUT, output ACK);
endinterface

// File: rtl/mem_phase_timer.sv
// rtl/mem_phase_timer.sv - per-phase cycle counter; expired once enable has been held TIMEOUT cycles
module mem_phase_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic CLK,
  input  logic nRST,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge CLK) begin
    if (!nRST || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

  // Fires in the TIMEOUT-th enabled cycle so the FSM leaves on that edge.
  assign expired = enable && (count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_initiator.sv
// rtl/mem_initiator.sv - single-outstanding REQ/ACK four-phase bus initiator with cmd/rsp ports
// Optional phase timeout abort: MEM_INITIATOR_TIMEOUT_EN
module mem_initiator
  import mem_bus_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_wen,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_wen,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  mem_initiator_if.master bus
);
  mem_state_t state, state_next;
  logic       accept;
  logic       phase_expired;

`ifdef MEM_INITIATOR_TIMEOUT_EN
  logic phase_clear, phase_en;

  assign phase_clear = (state != state_next);
  assign phase_en    = (state == REQ_HI) || (state == REQ_LO);

  mem_phase_timer #(.TIMEOUT(TIMEOUT)) u_phase_timer (
    .CLK     (CLK),
    .nRST    (nRST),
    .clear   (phase_clear),
    .enable  (phase_en),
    .expired (phase_expired)
  );
`else
  assign phase_expired = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = REQ_HI;
      REQ_HI:  if (bus.ACK || phase_expired) state_next = (bus.ACK) ? REQ_LO : RSP;
      REQ_LO:  if (!bus.ACK || phase_expired) state_next = RSP;
      RSP:     if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Holding off while ACK is still high keeps a late/stuck responder from seeing a new REQ.
  always_comb begin
    cmd_ready = nRST && (state == IDLE) && !bus.ACK;
    accept    = cmd_valid && cmd_ready;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      bus.ADDR  <= '0;
      bus.DIN   <= '0;
      bus.WEN   <= 1'b0;
      bus.REQ   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_wen   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            bus.ADDR <= cmd_addr;
            bus.DIN  <= cmd_wdata;
            bus.WEN  <= cmd_wen;
            bus.REQ  <= 1'b1;
            rsp_wen  <= cmd_wen;
            rsp_err  <= 1'b0;
          end
        end
        REQ_HI: begin
          if (bus.ACK) begin
            rsp_rdata <= bus.WEN ? '0 : bus.DOUT;
            bus.REQ   <= 1'b0;
          end else if (phase_expired) begin
            bus.REQ   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
          end
        end
        REQ_LO: begin
          if (!bus.ACK) begin
            rsp_valid <= 1'b1;
          end else if (phase_expired) begin
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
          end
        end
        RSP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule
